// File: rtl/response_framer_pkg.sv
// Shared types and constants for response_framer: bus widths, state encoding
// and the VLQ group thresholds used by the encoder.
package response_framer_pkg;

  localparam int unsigned WORD_W    = 33;
  localparam int unsigned VAL_W     = 32;
  localparam int unsigned VLQ_BYTES = 5;
  localparam int unsigned VLQ_VEC_W = 8 * VLQ_BYTES;

  // A group is needed when the value lies outside [LO, HI) for that shift
  localparam int VLQ_LO28 = -(1 << 26);
  localparam int VLQ_HI28 = 3 << 26;
  localparam int VLQ_LO21 = -(1 << 19);
  localparam int VLQ_HI21 = 3 << 19;
  localparam int VLQ_LO14 = -(1 << 12);
  localparam int VLQ_HI14 = 3 << 12;
  localparam int VLQ_LO7  = -(1 << 5);
  localparam int VLQ_HI7  = 3 << 5;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    ENC_ID,
    ENC_PARAM,
    DONE
  } state_e;

  function automatic logic vlq_out_of_range(input logic signed [31:0] v,
                                            input int lo, input int hi);
    return (v < lo) || (v >= hi);
  endfunction

endpackage

// File: rtl/response_framer_if.sv
// Unit response bus plus downstream byte stream seen by response_framer.
interface response_framer_if;
  import response_framer_pkg::*;

  logic [WORD_W-1:0] param_data;
  logic              param_write;
  logic              invol_req;
  logic              invol_grant;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output param_data, param_write, invol_req, out_ready,
    input  invol_grant, out_data, out_valid, out_last
  );

  modport slave (
    input  param_data, param_write, invol_req, out_ready,
    output invol_grant, out_data, out_valid, out_last
  );

endinterface

// File: rtl/response_framer_vlq_encoder.sv
// Combinational VLQ encoder: byte count (1-5) and bytes packed first-out in
// the low byte of the vector.
module response_framer_vlq_encoder
  import response_framer_pkg::*;
(
  input  logic [VAL_W-1:0]     val_i,
  output logic [2:0]           cnt_o,
  output logic [VLQ_VEC_W-1:0] bytes_o
);

  logic signed [31:0] sval;
  logic f28, f21, f14, f7;
  logic [7:0] g28, g21, g14, g7, g0;

  assign sval = $signed(val_i);

  // Once a higher group fires every lower group must follow
  assign f28 = vlq_out_of_range(sval, VLQ_LO28, VLQ_HI28);
  assign f21 = f28 | vlq_out_of_range(sval, VLQ_LO21, VLQ_HI21);
  assign f14 = f21 | vlq_out_of_range(sval, VLQ_LO14, VLQ_HI14);
  assign f7  = f14 | vlq_out_of_range(sval, VLQ_LO7, VLQ_HI7);

  assign g28 = {1'b1, 7'(sval >>> 28)};
  assign g21 = {1'b1, 7'(sval >>> 21)};
  assign g14 = {1'b1, 7'(sval >>> 14)};
  assign g7  = {1'b1, 7'(sval >>> 7)};
  assign g0  = {1'b0, val_i[6:0]};

  assign cnt_o = 3'd1 + 3'(f7) + 3'(f14) + 3'(f21) + 3'(f28);

  always_comb begin
    bytes_o = '0;
    case (cnt_o)
      3'd5:    bytes_o = {g0, g7, g14, g21, g28};
      3'd4:    bytes_o = {8'h00, g0, g7, g14, g21};
      3'd3:    bytes_o = {16'h0000, g0, g7, g14};
      3'd2:    bytes_o = {24'h000000, g0, g7};
      default: bytes_o = {32'h00000000, g0};
    endcase
  end

endmodule

// File: rtl/response_framer.sv
// Buffers one unit response and re-emits it as a VLQ byte stream (ID first).
// Optional RESPONSE_FRAMER_STATS_EN adds frames_sent/frames_dropped counters.
module response_framer
  import response_framer_pkg::*;
#(
  parameter int unsigned MAX_PARAMS = 8,
  parameter int unsigned ID_BITS    = 8
) (
  input  logic               clk,
  input  logic               rst,
  response_framer_if.slave   bus,
  output logic               busy,
  output logic               overrun,
  input  logic               overrun_clr
`ifdef RESPONSE_FRAMER_STATS_EN
  ,
  output logic [15:0]        frames_sent,
  output logic [15:0]        frames_dropped
`endif
);

  localparam int unsigned PTR_W = $clog2(MAX_PARAMS);
  localparam int unsigned CNT_W = $clog2(MAX_PARAMS + 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     idx_q, idx_d, nxt_idx;
  logic [VAL_W-1:0]     buf_q [MAX_PARAMS];
  logic [VLQ_VEC_W-1:0] sr_q, sr_d;
  logic [2:0]           rem_q, rem_d;
  logic                 valid_q, valid_d, last_q, last_d, wlast_q, wlast_d;
  logic                 busy_q, busy_d, pw_q, drop_q, drop_d;
  logic                 ovr_q, ovr_d, grant_q, grant_d;
  logic                 wr_en, load, shift, wlast_load, ovf, accept, drop_word;
  logic [PTR_W-1:0]     wr_idx;
  logic [VAL_W-1:0]     enc_val;
  logic [2:0]           enc_cnt;
  logic [VLQ_VEC_W-1:0] enc_bytes;
  logic                 unused_param_msb;

  response_framer_vlq_encoder u_vlq_encoder (
    .val_i   (enc_val),
    .cnt_o   (enc_cnt),
    .bytes_o (enc_bytes)
  );

  assign accept    = valid_q & bus.out_ready;
  assign nxt_idx   = idx_q + PTR_W'(1);
  // Words of a response that arrived while busy are swallowed until its ID cycle
  assign drop_word = bus.param_write & (drop_q | (busy_q & (state_q != COLLECT)));
  assign drop_d    = drop_word;
  assign ovr_d     = drop_word | ovf | (ovr_q & ~overrun_clr);
  assign grant_d   = bus.invol_req & (state_q == IDLE) & ~bus.param_write & ~grant_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sr_d       = sr_q;
    rem_d      = rem_q;
    valid_d    = valid_q;
    last_d     = last_q;
    wlast_d    = wlast_q;
    busy_d     = busy_q;
    wr_en      = 1'b0;
    wr_idx     = '0;
    load       = 1'b0;
    shift      = 1'b0;
    wlast_load = 1'b0;
    ovf        = 1'b0;
    enc_val    = '0;
    case (state_q)
      IDLE: begin
        if (bus.param_write && !drop_q) begin
          wr_en   = 1'b1;
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.param_write) begin
          if (cnt_q == CNT_W'(MAX_PARAMS)) begin
            ovf = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wr_idx = PTR_W'(cnt_q);
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end else if (pw_q) begin
          enc_val = VAL_W'(bus.param_data[ID_BITS-1:0]);
          load    = 1'b1;
          state_d = ENC_ID;
        end
      end
      ENC_ID: begin
        enc_val = buf_q[0];
        if (accept) begin
          if (rem_q > 3'd1) begin
            shift = 1'b1;
          end else if (cnt_q == '0) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            load       = 1'b1;
            wlast_load = (cnt_q == CNT_W'(1));
            idx_d      = '0;
            state_d    = ENC_PARAM;
          end
        end
      end
      ENC_PARAM: begin
        enc_val = buf_q[nxt_idx];
        if (accept) begin
          if (rem_q > 3'd1) begin
            shift = 1'b1;
          end else if (CNT_W'(idx_q) == cnt_q - CNT_W'(1)) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            load       = 1'b1;
            idx_d      = nxt_idx;
            wlast_load = (CNT_W'(nxt_idx) == cnt_q - CNT_W'(1));
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Shift register either reloads from the encoder or drops the sent byte
    if (load) begin
      sr_d    = enc_bytes;
      rem_d   = enc_cnt;
      valid_d = 1'b1;
      wlast_d = wlast_load;
      last_d  = wlast_load && (enc_cnt == 3'd1);
    end else if (shift) begin
      sr_d   = sr_q >> 8;
      rem_d  = rem_q - 3'd1;
      last_d = wlast_q && (rem_q == 3'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sr_q    <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      wlast_q <= 1'b0;
      busy_q  <= 1'b0;
      pw_q    <= 1'b0;
      drop_q  <= 1'b0;
      ovr_q   <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      wlast_q <= wlast_d;
      busy_q  <= busy_d;
      pw_q    <= bus.param_write;
      drop_q  <= drop_d;
      ovr_q   <= ovr_d;
      grant_q <= grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= bus.param_data[VAL_W-1:0];
  end

`ifdef RESPONSE_FRAMER_STATS_EN
  logic [15:0] sent_q, dropped_q;
  logic        drop_start;

  assign drop_start = bus.param_write & ~drop_q & busy_q & (state_q != COLLECT);

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      if (accept && last_q) sent_q <= sent_q + 16'd1;
      if (drop_start) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign frames_sent    = sent_q;
  assign frames_dropped = dropped_q;
`endif

  assign unused_param_msb = bus.param_data[WORD_W-1];
  assign bus.invol_grant  = grant_q;
  assign bus.out_data     = sr_q[7:0];
  assign bus.out_valid    = valid_q;
  assign bus.out_last     = last_q;
  assign busy             = busy_q;
  assign overrun          = ovr_q;

endmodule

// File: tb/tb_response_framer.sv
// Directed bench for response_framer with a byte scoreboard fed at stimulus time.
module tb_response_framer;
  import response_framer_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overrun_clr = 1'b0;
  logic busy, overrun;
`ifdef RESPONSE_FRAMER_STATS_EN
  logic [15:0] frames_sent, frames_dropped;
`endif

  response_framer_if bus_if ();

  response_framer #(.MAX_PARAMS(8), .ID_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef RESPONSE_FRAMER_STATS_EN
    ,
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped)
`endif
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic       stall_q = 1'b0;
  logic [7:0] held_data = '0;
  logic       held_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void expect_byte(input logic [7:0] d, input logic l);
    sb.push_back('{data: d, last: l});
  endfunction

  task automatic send_word(input logic [32:0] w);
    bus_if.param_data  = w;
    bus_if.param_write = 1'b1;
    tick();
  endtask

  task automatic send_id(input logic [7:0] id);
    bus_if.param_write = 1'b0;
    bus_if.param_data  = 33'(id);
    tick();
    bus_if.param_data  = '0;
  endtask

  task automatic wait_done(input int max_cycles, input bit toggle);
    int c = 0;
    while ((sb.size() != 0 || busy === 1'b1) && c < max_cycles) begin
      if (toggle) bus_if.out_ready = ~bus_if.out_ready;
      tick();
      c++;
    end
    bus_if.out_ready = 1'b1;
    check("drain_timeout", 32'(c < max_cycles), 32'd1);
  endtask

  // Output monitor: pops the scoreboard on each accepted byte, checks stalls hold
  always @(negedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 32'(bus_if.out_valid), 32'd1);
        check("stall_data", 32'(bus_if.out_data), 32'(held_data));
        check("stall_last", 32'(bus_if.out_last), 32'(held_last));
      end
      if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("out_data", 32'(bus_if.out_data), 32'(sb[0].data));
          check("out_last", 32'(bus_if.out_last), 32'(sb[0].last));
          sb.delete(0);
        end
        stall_q <= 1'b0;
      end else if (bus_if.out_valid === 1'b1) begin
        stall_q   <= 1'b1;
        held_data <= bus_if.out_data;
        held_last <= bus_if.out_last;
      end else begin
        stall_q <= 1'b0;
      end
    end
  end

  initial begin
    int  c;
    bit  got;
    bus_if.param_data  = '0;
    bus_if.param_write = 1'b0;
    bus_if.invol_req   = 1'b0;
    bus_if.out_ready   = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_grant", 32'(bus_if.invol_grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_last", 32'(bus_if.out_last), 32'd0);
    check("rst_data", 32'(bus_if.out_data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Two params (bit 32 set on the first must be ignored), ID 0x55
    expect_byte(8'h55, 1'b0); expect_byte(8'h03, 1'b0);
    expect_byte(8'h80, 1'b0); expect_byte(8'h64, 1'b1);
    send_word(33'h1_0000_0003);
    check("busy_set", 32'(busy), 32'd1);
    send_word(33'd100);
    send_id(8'h55);
    check("first_valid", 32'(bus_if.out_valid), 32'd1);
    check("first_data", 32'(bus_if.out_data), 32'h55);
    wait_done(50, 1'b0);
    check("busy_clear", 32'(busy), 32'd0);
    check("idle_valid", 32'(bus_if.out_valid), 32'd0);

    // Five-byte word
    expect_byte(8'h10, 1'b0); expect_byte(8'h81, 1'b0); expect_byte(8'h91, 1'b0);
    expect_byte(8'hD1, 1'b0); expect_byte(8'hAC, 1'b0); expect_byte(8'h78, 1'b1);
    send_word(33'h0_1234_5678);
    send_id(8'h10);
    wait_done(50, 1'b0);

    // Negative values; ID 0x70 needs two bytes
    expect_byte(8'h01, 1'b0); expect_byte(8'h7F, 1'b1);
    send_word(33'h0_FFFF_FFFF);
    send_id(8'h01);
    wait_done(50, 1'b0);
    expect_byte(8'h80, 1'b0); expect_byte(8'h70, 1'b0);
    expect_byte(8'hFF, 1'b0); expect_byte(8'h5F, 1'b1);
    send_word(33'h0_FFFF_FFDF);
    send_id(8'h70);
    wait_done(50, 1'b0);

    // First response again with out_ready toggling
    expect_byte(8'h55, 1'b0); expect_byte(8'h03, 1'b0);
    expect_byte(8'h80, 1'b0); expect_byte(8'h64, 1'b1);
    send_word(33'h1_0000_0003);
    send_word(33'd100);
    send_id(8'h55);
    wait_done(80, 1'b1);

    // Second response while the first is held: dropped, overrun set
    bus_if.out_ready = 1'b0;
    expect_byte(8'h10, 1'b0); expect_byte(8'h81, 1'b0); expect_byte(8'h91, 1'b0);
    expect_byte(8'hD1, 1'b0); expect_byte(8'hAC, 1'b0); expect_byte(8'h78, 1'b1);
    send_word(33'h0_1234_5678);
    send_id(8'h10);
    send_word(33'd5);
    send_word(33'd6);
    send_id(8'h77);
    check("overrun_set", 32'(overrun), 32'd1);
    check("held_data", 32'(bus_if.out_data), 32'h10);
    bus_if.out_ready = 1'b1;
    wait_done(50, 1'b0);
    check("overrun_sticky", 32'(overrun), 32'd1);
`ifdef RESPONSE_FRAMER_STATS_EN
    check("frames_dropped", 32'(frames_dropped), 32'd1);
`endif
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overrun_clr", 32'(overrun), 32'd0);

    // Nine words into an eight-deep buffer: ninth discarded
    expect_byte(8'h40, 1'b0);
    for (int i = 1; i <= 8; i++) expect_byte(8'(i), (i == 8));
    for (int i = 1; i <= 9; i++) send_word(33'(i));
    send_id(8'h40);
    check("overflow_set", 32'(overrun), 32'd1);
    wait_done(60, 1'b0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("overflow_clr", 32'(overrun), 32'd0);

    // Grant in IDLE: one pulse only
    bus_if.invol_req = 1'b1;
    tick();
    check("grant_pulse", 32'(bus_if.invol_grant), 32'd1);
    tick();
    check("grant_single", 32'(bus_if.invol_grant), 32'd0);
    bus_if.invol_req = 1'b0;
    tick();

    // Grant deferred until the framer is back in IDLE
    bus_if.out_ready = 1'b0;
    expect_byte(8'h30, 1'b0); expect_byte(8'h01, 1'b1);
    send_word(33'd1);
    send_id(8'h30);
    bus_if.invol_req = 1'b1;
    tick();
    check("grant_busy", 32'(bus_if.invol_grant), 32'd0);
    bus_if.out_ready = 1'b1;
    c = 0;
    got = 1'b0;
    while (!got && c < 20) begin
      if (bus_if.invol_grant === 1'b1) got = 1'b1;
      else begin
        tick();
        c++;
      end
    end
    check("grant_after_done", 32'(got), 32'd1);
    check("grant_not_busy", 32'(busy), 32'd0);
    check("grant_sb_empty", 32'(sb.size()), 32'd0);
    bus_if.invol_req = 1'b0;
    tick();
    tick();

`ifdef RESPONSE_FRAMER_STATS_EN
    check("frames_sent", 32'(frames_sent), 32'd8);
`endif
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
